mips_multicycle_ctrl: RTL and testbench
=======================================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Next-gen control FSM for the multicycle MIPS datapath. Decodes opcode and drives all datapath strobes.
//  Adds memory wait-state handshake (mem_ready), a per-access timeout, and I-type ALU ops (ADDI/ANDI/ORI/SLTI).
//  Adds a sticky ERROR state and a retire pulse. Every output is fully defined in every state: no latches, no X.
//  Sits between the IR opcode field and the datapath mux/enable inputs.
// PARAMETERS
//  OPW      6   opcode width
//  TOW      4   timeout counter width
//  TIMEOUT  12  max cycles a memory state waits for mem_ready before ERROR (1..2**TOW-1)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous active-high reset
//  opcode       in   OPW  IR[31:26]
//  mem_ready    in   1    memory completes the current access this cycle
//  PCWriteCond  out  1    conditional PC write (branch)
//  PCWrite      out  1    unconditional PC write
//  IorD         out  1    0=PC address, 1=ALUOut address
//  MemRead      out  1    memory read request (held until mem_ready)
//  MemWrite     out  1    memory write request (held until mem_ready)
//  MemtoReg     out  1    1=MDR to RF write data
//  IRWrite      out  1    IR load enable
//  RegWrite     out  1    RF write enable
//  RegDst       out  1    1=rd, 0=rt
//  ALUSrcA      out  1    0=PC, 1=A
//  ExtZero      out  1    1=zero-extend imm (ANDI/ORI), 0=sign-extend
//  BranchNe     out  1    1=branch on !zero (BNE); 0=on zero
//  PCSource     out  2    00=ALU, 01=ALUOut, 10=jump target
//  ALUSrcB      out  2    00=B, 01=4, 10=ext imm, 11=ext imm<<2
//  ALUOp        out  3    000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//  retire       out  1    1-cycle pulse on the last state of each instruction
//  err          out  1    sticky; high while in ERROR
//  curr_state   out  4    state encoding (debug)
// BEHAVIOUR
//  Encoding (pkg): INIT=F, FETCH=0, DECODE=1, MADDR=2, MEMLW=3, MEMR=4, MEMSW=5, EXEC=6, RCOMP=7, BRANCH=8, JUMP=9, IMMEX=A, IMMWB=B, ERROR=E.
//  Reset: state<=INIT, wait_cnt<=0. In INIT all outputs are 0 (incl. err, retire). INIT->FETCH unconditionally.
//  Unlisted outputs are 0 in every state.
//  The FSM is Moore, except IRWrite/PCWrite in FETCH, which are qualified by mem_ready.
//  FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00.
//    IRWrite=PCWrite=mem_ready. On mem_ready -> DECODE; else stay.
//  DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=000. Next state by opcode:
//    LW/SW -> MADDR; R(0) -> EXEC; BEQ -> BRANCH; J -> JUMP;
//    ADDI(08)/ANDI(0C)/ORI(0D)/SLTI(0A) -> IMMEX; other -> ERROR.
//  MADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. LW -> MEMLW; SW -> MEMSW.
//  MEMLW: MemRead=1, IorD=1. On mem_ready -> MEMR.
//  MEMSW: MemWrite=1, IorD=1. On mem_ready -> FETCH, retire=1.
//  MEMR: RegWrite=1, MemtoReg=1, RegDst=0, retire=1 -> FETCH.
//  EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010 -> RCOMP.
//  RCOMP: RegWrite=1, RegDst=1, retire=1 -> FETCH.
//  IMMEX: ALUSrcA=1, ALUSrcB=10. ALUOp: ADDI 000, ANDI 011, ORI 100, SLTI 101.
//    ExtZero=1 for ANDI/ORI -> IMMWB.
//  IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, retire=1 -> FETCH.
//    The IMMEX opcode is held by the IR (IRWrite=0); it needs no latch.
//  BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCWriteCond=1, PCSource=01, retire=1 -> FETCH.
//  JUMP: PCWrite=1, PCSource=10, retire=1 -> FETCH.
//  Timeout: wait_cnt clears on entry to FETCH/MEMLW/MEMSW and counts each cycle with mem_ready=0.
//    At wait_cnt==TIMEOUT-1 with mem_ready=0 -> ERROR. mem_ready in that same cycle wins (normal transition).
//  ERROR: err=1, all strobes 0. Left only by rst. Unencoded state values -> ERROR.
//  rst mid-access (any state): INIT next cycle. The pending write is dropped (MemWrite=0 in INIT).
// CONFIGURATION
//  MIPS_CTRL_BNE_EN defined: BNE(05) decodes to BRANCH, with BranchNe=1 in BRANCH.
//  Not defined: BNE -> ERROR, and BranchNe is tied 0.
// STRUCTURE
//  Package mips_ctrl_pkg: fsm_state enum, opcode localparams (LW, SW, BEQ, BNE, R, J, ADDI, ANDI, ORI, SLTI), ALUOp/ALUSrcB/PCSource codes.
//  Sub-module mips_imm_aluop_dec (comb): opcode -> {ALUOp, ExtZero} for IMMEX.
//  Single state register plus wait_cnt register. All outputs from one always_comb with defaults.
// TESTING
//  rst=1 for 2 clk, opcode=0 -> state F, all outputs 0. Release -> FETCH next cycle.
//  FETCH with mem_ready low 3 cycles then high:
//    MemRead=1 for 4 cycles; IRWrite=PCWrite=1 only in the 4th cycle; then DECODE.
//  LW, zero-wait memory: FETCH, DECODE, MADDR, MEMLW, MEMR.
//    5 cycles; RegWrite=MemtoReg=1 in MEMR; exactly one retire pulse.
//  ORI (0D): IMMEX shows ALUOp=100, ExtZero=1. IMMWB shows RegWrite=1, RegDst=0.
//  MEMSW with mem_ready held low, TIMEOUT=12: ERROR after 12 wait cycles, err=1 and sticky; rst -> INIT.
//  opcode 05: ERROR without MIPS_CTRL_BNE_EN; BRANCH with BranchNe=1 when it is defined.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and codes for the multicycle MIPS control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'h0,
    S_DECODE = 4'h1,
    S_MADDR  = 4'h2,
    S_MEMLW  = 4'h3,
    S_MEMR   = 4'h4,
    S_MEMSW  = 4'h5,
    S_EXEC   = 4'h6,
    S_RCOMP  = 4'h7,
    S_BRANCH = 4'h8,
    S_JUMP   = 4'h9,
    S_IMMEX  = 4'hA,
    S_IMMWB  = 4'hB,
    S_ERROR  = 4'hE,
    S_INIT   = 4'hF
  } fsm_state;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/mips_imm_aluop_dec.sv
// I-type opcode to ALU operation and immediate-extension select.
module mips_imm_aluop_dec
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic [OPW-1:0] i_opcode,
  output logic [2:0]     o_alu_op,
  output logic           o_ext_zero
);

  // Logical ops take a zero-extended immediate; arithmetic/compare sign-extend.
  always_comb begin
    o_alu_op   = ALU_ADD;
    o_ext_zero = 1'b0;
    case (i_opcode)
      OPW'(OP_ADDI): o_alu_op = ALU_ADD;
      OPW'(OP_ANDI): begin o_alu_op = ALU_AND; o_ext_zero = 1'b1; end
      OPW'(OP_ORI):  begin o_alu_op = ALU_OR;  o_ext_zero = 1'b1; end
      OPW'(OP_SLTI): o_alu_op = ALU_SLT;
      default:       o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM with memory wait states, access timeout and sticky error.
// Optional: define MIPS_CTRL_BNE_EN to decode BNE into the BRANCH state with BranchNe=1.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int TOW     = 4,
  parameter int TIMEOUT = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           PCWriteCond,
  output logic           PCWrite,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           ALUSrcA,
  output logic           ExtZero,
  output logic           BranchNe,
  output logic [1:0]     PCSource,
  output logic [1:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           retire,
  output logic           err,
  output logic [3:0]     curr_state
);

  fsm_state         r_state;
  fsm_state         w_next;
  logic [TOW-1:0]   r_wait_cnt;
  logic [TOW-1:0]   w_wait_nxt;
  logic             w_is_wait;
  logic             w_tmo;
  logic [2:0]       w_imm_alu_op;
  logic             w_imm_ext_zero;

  mips_imm_aluop_dec #(.OPW(OPW)) u_imm_dec (
    .i_opcode   (opcode),
    .o_alu_op   (w_imm_alu_op),
    .o_ext_zero (w_imm_ext_zero)
  );

  assign w_is_wait = (r_state == S_FETCH) || (r_state == S_MEMLW) || (r_state == S_MEMSW);
  assign w_tmo     = (r_wait_cnt == TOW'(TIMEOUT - 1)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_INIT;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    w_next = S_ERROR;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = mem_ready ? S_DECODE : (w_tmo ? S_ERROR : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OPW'(OP_LW), OPW'(OP_SW):                     w_next = S_MADDR;
          OPW'(OP_R):                                   w_next = S_EXEC;
          OPW'(OP_BEQ):                                 w_next = S_BRANCH;
`ifdef MIPS_CTRL_BNE_EN
          OPW'(OP_BNE):                                 w_next = S_BRANCH;
`endif
          OPW'(OP_J):                                   w_next = S_JUMP;
          OPW'(OP_ADDI), OPW'(OP_ANDI),
          OPW'(OP_ORI),  OPW'(OP_SLTI):                 w_next = S_IMMEX;
          default:                                      w_next = S_ERROR;
        endcase
      end
      S_MADDR: begin
        if (opcode == OPW'(OP_LW))      w_next = S_MEMLW;
        else if (opcode == OPW'(OP_SW)) w_next = S_MEMSW;
        else                            w_next = S_ERROR;
      end
      S_MEMLW:  w_next = mem_ready ? S_MEMR  : (w_tmo ? S_ERROR : S_MEMLW);
      S_MEMSW:  w_next = mem_ready ? S_FETCH : (w_tmo ? S_ERROR : S_MEMSW);
      S_MEMR:   w_next = S_FETCH;
      S_EXEC:   w_next = S_RCOMP;
      S_RCOMP:  w_next = S_FETCH;
      S_IMMEX:  w_next = S_IMMWB;
      S_IMMWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_ERROR;
    endcase
    // Counter restarts whenever a wait state is newly entered.
    if (w_next != r_state)            w_wait_nxt = '0;
    else if (w_is_wait && !mem_ready) w_wait_nxt = r_wait_cnt + 1'b1;
    else                              w_wait_nxt = r_wait_cnt;
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ExtZero     = 1'b0;
    BranchNe    = 1'b0;
    PCSource    = PCS_ALU;
    ALUSrcB     = SRCB_B;
    ALUOp       = ALU_ADD;
    retire      = 1'b0;
    err         = 1'b0;
    curr_state  = r_state;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = SRCB_IMM_SH;
      S_MADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMLW: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMSW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      S_MEMR: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_RCOMP: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
      end
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = w_imm_alu_op;
        ExtZero = w_imm_ext_zero;
      end
      S_IMMWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        retire      = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
        BranchNe    = (opcode == OPW'(OP_BNE));
`else
        BranchNe    = 1'b0;
`endif
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCS_JUMP;
        retire   = 1'b1;
      end
      S_ERROR: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl with an output scoreboard.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, ExtZero, BranchNe, retire, err;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic [3:0] curr_state;

  mips_multicycle_ctrl #(.OPW(6), .TOW(4), .TIMEOUT(12)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ExtZero(ExtZero), .BranchNe(BranchNe),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .retire(retire),
    .err(err), .curr_state(curr_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Observed vector: {state, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
  //   IRWrite, RegWrite, RegDst, ALUSrcA, ExtZero, BranchNe, PCSource, ALUSrcB, ALUOp, retire, err}
  localparam int W = 25;
  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] ev(
    input logic [3:0] st,
    input logic pcwc, input logic pcw, input logic iord, input logic mr, input logic mw,
    input logic m2r, input logic irw, input logic rw, input logic rd, input logic asa,
    input logic ez, input logic bne, input logic [1:0] pcs, input logic [1:0] asb,
    input logic [2:0] aop, input logic ret, input logic er);
    return {st, pcwc, pcw, iord, mr, mw, m2r, irw, rw, rd, asa, ez, bne, pcs, asb, aop, ret, er};
  endfunction

  //                         st    cw pw id mr mw mt ir rw rd sa ez bn pcs    asb    aop     rt er
  wire [W-1:0] E_INIT   = ev(4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  wire [W-1:0] E_FWAIT  = ev(4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0, 0);
  wire [W-1:0] E_FGO    = ev(4'h0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0, 0);
  wire [W-1:0] E_DECODE = ev(4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 3'b000, 0, 0);
  wire [W-1:0] E_MADDR  = ev(4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 3'b000, 0, 0);
  wire [W-1:0] E_MEMLW  = ev(4'h3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  wire [W-1:0] E_MEMR   = ev(4'h4, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
  wire [W-1:0] E_MEMSW  = ev(4'h5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0);
  wire [W-1:0] E_SWGO   = ev(4'h5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
  wire [W-1:0] E_EXEC   = ev(4'h6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 3'b010, 0, 0);
  wire [W-1:0] E_RCOMP  = ev(4'h7, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
  wire [W-1:0] E_BEQ    = ev(4'h8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 3'b001, 1, 0);
  wire [W-1:0] E_BNE    = ev(4'h8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2'b01, 2'b00, 3'b001, 1, 0);
  wire [W-1:0] E_JUMP   = ev(4'h9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 3'b000, 1, 0);
  wire [W-1:0] E_IMMWB  = ev(4'hB, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 1, 0);
  wire [W-1:0] E_ERROR  = ev(4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1);

  function automatic logic [W-1:0] e_immex(input logic [2:0] aop, input logic ez);
    return ev(4'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ez, 0, 2'b00, 2'b10, aop, 0, 0);
  endfunction

  // driver: apply inputs for one cycle and queue the response expected in that cycle
  task automatic step(input logic [5:0] op, input logic mr, input logic [W-1:0] e);
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [5:0] op);
    step(op, 1'b1, E_FGO);
    step(op, 1'b0, E_DECODE);
  endtask

  // monitor / scoreboard: outputs sampled on the falling edge
  always @(negedge clk) begin
    logic [W-1:0] got, want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {curr_state, PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
              RegWrite, RegDst, ALUSrcA, ExtZero, BranchNe, PCSource, ALUSrcB, ALUOp, retire, err};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL vec%0d state=%h got=%h expected=%h", vectors, curr_state, got, want);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] imm_op  [3] = '{6'h08, 6'h0C, 6'h0A};
  logic [2:0] imm_aop [3] = '{3'b000, 3'b011, 3'b101};
  logic       imm_ez  [3] = '{1'b0, 1'b1, 1'b0};

  initial begin
    @(posedge clk); #1;
    // reset held two cycles, then INIT -> FETCH
    step(6'h00, 1'b0, E_INIT);
    rst = 1'b0;
    step(6'h00, 1'b0, E_INIT);
    // fetch with 3 wait cycles, then LW with one memory wait
    repeat (3) step(6'h23, 1'b0, E_FWAIT);
    step(6'h23, 1'b1, E_FGO);
    step(6'h23, 1'b0, E_DECODE);
    step(6'h23, 1'b0, E_MADDR);
    step(6'h23, 1'b0, E_MEMLW);
    step(6'h23, 1'b1, E_MEMLW);
    step(6'h23, 1'b0, E_MEMR);
    // LW with zero-wait memory
    fetch_decode(6'h23);
    step(6'h23, 1'b0, E_MADDR);
    step(6'h23, 1'b1, E_MEMLW);
    step(6'h23, 1'b0, E_MEMR);
    // R-type
    fetch_decode(6'h00);
    step(6'h00, 1'b0, E_EXEC);
    step(6'h00, 1'b0, E_RCOMP);
    // ORI, then ADDI / ANDI / SLTI
    fetch_decode(6'h0D);
    step(6'h0D, 1'b0, e_immex(3'b100, 1'b1));
    step(6'h0D, 1'b0, E_IMMWB);
    for (int i = 0; i < 3; i++) begin
      fetch_decode(imm_op[i]);
      step(imm_op[i], 1'b0, e_immex(imm_aop[i], imm_ez[i]));
      step(imm_op[i], 1'b0, E_IMMWB);
    end
    // BEQ and J
    fetch_decode(6'h04);
    step(6'h04, 1'b0, E_BEQ);
    fetch_decode(6'h02);
    step(6'h02, 1'b0, E_JUMP);
    // SW with two wait cycles
    fetch_decode(6'h2B);
    step(6'h2B, 1'b0, E_MADDR);
    step(6'h2B, 1'b0, E_MEMSW);
    step(6'h2B, 1'b0, E_MEMSW);
    step(6'h2B, 1'b1, E_SWGO);
    // fetch boundary: ready on the last permitted cycle wins over timeout
    repeat (11) step(6'h02, 1'b0, E_FWAIT);
    step(6'h02, 1'b1, E_FGO);
    step(6'h02, 1'b0, E_DECODE);
    step(6'h02, 1'b0, E_JUMP);
    // opcode 05
    fetch_decode(6'h05);
`ifdef MIPS_CTRL_BNE_EN
    step(6'h05, 1'b0, E_BNE);
    step(6'h3F, 1'b0, E_FWAIT);
    step(6'h3F, 1'b1, E_FGO);
    step(6'h3F, 1'b0, E_DECODE);
`endif
    step(6'h05, 1'b1, E_ERROR);
    rst = 1'b1;
    step(6'h05, 1'b0, E_ERROR);
    rst = 1'b0;
    step(6'h00, 1'b0, E_INIT);
    // SW timeout: 12 unanswered cycles -> sticky ERROR
    fetch_decode(6'h2B);
    step(6'h2B, 1'b0, E_MADDR);
    repeat (12) step(6'h2B, 1'b0, E_MEMSW);
    step(6'h2B, 1'b1, E_ERROR);
    step(6'h00, 1'b1, E_ERROR);
    step(6'h23, 1'b0, E_ERROR);
    rst = 1'b1;
    step(6'h23, 1'b0, E_ERROR);
    rst = 1'b0;
    step(6'h00, 1'b0, E_INIT);
    // reset mid-store drops the write
    fetch_decode(6'h2B);
    step(6'h2B, 1'b0, E_MADDR);
    rst = 1'b1;
    step(6'h2B, 1'b0, E_MEMSW);
    rst = 1'b0;
    step(6'h2B, 1'b0, E_INIT);
    step(6'h2B, 1'b0, E_FWAIT);
    // drain the scoreboard
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
